// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART link controller.
// Header byte = {HDR_MAGIC, 2'b00, id}.
package uart_link_pkg;
  localparam logic [3:0] HDR_MAGIC = 4'hA;
  localparam int ID_W = 2;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_e;
  typedef enum logic {HUNT, DATA} rx_state_e;
endpackage

// File: rtl/uart_link_ctrl_rr_arbiter.sv
// Round-robin request picker.
// The combinational pick starts at the registered pointer.
// The pointer moves past the winner whenever a grant is taken.
module rr_arbiter
  import uart_link_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic               o_any,
  output logic [ID_W-1:0]    o_winner
);

  logic [ID_W-1:0] r_ptr;
  logic            w_any;
  logic [ID_W-1:0] w_winner;

  // Scan requesters in priority order r_ptr, r_ptr+1, ... (mod NUM_REQ).
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_any && (j == ((int'(r_ptr) + i) % NUM_REQ)) && i_req[j]) begin
          w_any    = 1'b1;
          w_winner = ID_W'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (i_advance && w_any) begin
      r_ptr <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(w_winner + 1'b1);
    end
  end

  assign o_any    = w_any;
  assign o_winner = w_winner;

endmodule

// File: rtl/uart_link_ctrl.sv
// Shares one byte UART between NUM_REQ word requesters (TX).
// Reassembles incoming header+data frames (RX).
module uart_link_ctrl
  import uart_link_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int RX_TIMEOUT = 100000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [7:0]                    uart_data,
  output logic                          uart_en,
  input  logic                          uart_tx_busy,
  input  logic                          uart_rx_ready,
  input  logic [7:0]                    uart_rx_data,
  output logic                          rx_valid,
  output logic [ID_W-1:0]               rx_id,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          frame_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(BYTES + 1);
  localparam int TMR_W = $clog2(RX_TIMEOUT + 1);

  tx_state_e              r_txState, w_txNext;
  logic [IDX_W-1:0]       r_byteIdx;
  logic [DATA_WIDTH-1:0]  r_txWord;
  logic [ID_W-1:0]        r_txId;
  logic [NUM_REQ-1:0]     r_reqReady;
  logic                   w_any;
  logic [ID_W-1:0]        w_winner;
  logic                   w_grant;
  logic [DATA_WIDTH-1:0]  w_selWord;
  logic [7:0]             w_curByte;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .i_req     (req_valid),
    .i_advance (r_txState == IDLE),
    .o_any     (w_any),
    .o_winner  (w_winner)
  );

  assign w_grant = (r_txState == IDLE) && w_any;

  always_comb begin
    w_selWord = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) w_selWord = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Byte 0 is the header; bytes 1..BYTES walk the word LSB first.
  always_comb begin
    w_curByte = {HDR_MAGIC, {(4-ID_W){1'b0}}, r_txId};
    for (int k = 1; k <= BYTES; k++) begin
      if (r_byteIdx == IDX_W'(k)) w_curByte = r_txWord[8*(k-1) +: 8];
    end
  end

  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      IDLE:      if (w_grant) w_txNext = LOAD;
      LOAD:      if (!uart_tx_busy) w_txNext = WAIT_BUSY;
      WAIT_BUSY: if (uart_tx_busy) w_txNext = WAIT_DONE;
      WAIT_DONE: if (!uart_tx_busy) w_txNext = (r_byteIdx == IDX_W'(BYTES)) ? IDLE : LOAD;
      default:   w_txNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_txState <= IDLE;
    else       r_txState <= w_txNext;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byteIdx  <= '0;
      r_txWord   <= '0;
      r_txId     <= '0;
      r_reqReady <= '0;
    end else begin
      r_reqReady <= '0;
      if (w_grant) begin
        r_reqReady <= NUM_REQ'(1) << w_winner;
        r_txWord   <= w_selWord;
        r_txId     <= w_winner;
        r_byteIdx  <= '0;
      end else if (r_txState == WAIT_DONE && !uart_tx_busy && r_byteIdx != IDX_W'(BYTES)) begin
        r_byteIdx <= r_byteIdx + 1'b1;
      end
    end
  end

  // The enable is gated by busy so a byte is never handed to a busy UART.
  assign uart_en   = (r_txState == LOAD) && !uart_tx_busy;
  assign uart_data = (r_txState == IDLE) ? 8'h00 : w_curByte;
  assign req_ready = r_reqReady;

  rx_state_e              r_rxState, w_rxNext;
  logic                   r_rdyDly;
  logic [IDX_W-1:0]       r_rxCnt;
  logic [DATA_WIDTH-1:0]  r_rxShift;
  logic [DATA_WIDTH-1:0]  w_shiftNext;
  logic [ID_W-1:0]        r_hdrId;
  logic [TMR_W-1:0]       r_rxTimer;
  logic                   r_rxValid;
  logic [ID_W-1:0]        r_rxId;
  logic [DATA_WIDTH-1:0]  r_rxData;
  logic                   r_frameErr;
  logic                   w_strobe;
  logic                   w_hdrOk;
  logic                   w_last;
  logic                   w_timeout;

  assign w_strobe  = uart_rx_ready && !r_rdyDly;
  assign w_hdrOk   = (uart_rx_data[7:4] == HDR_MAGIC);
  assign w_last    = (r_rxState == DATA) && w_strobe && (r_rxCnt == IDX_W'(BYTES - 1));
  assign w_timeout = (r_rxState == DATA) && !w_strobe && (r_rxTimer == TMR_W'(RX_TIMEOUT - 1));

  always_comb begin
    w_shiftNext = r_rxShift;
    for (int k = 0; k < BYTES; k++) begin
      if (r_rxCnt == IDX_W'(k)) w_shiftNext[8*k +: 8] = uart_rx_data;
    end
  end

  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      HUNT:    if (w_strobe && w_hdrOk) w_rxNext = DATA;
      DATA:    if (w_last || w_timeout) w_rxNext = HUNT;
      default: w_rxNext = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rxState <= HUNT;
    else       r_rxState <= w_rxNext;
  end

  // Timer restarts on every byte and only runs while a frame is open.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdyDly   <= 1'b0;
      r_rxCnt    <= '0;
      r_rxShift  <= '0;
      r_hdrId    <= '0;
      r_rxTimer  <= '0;
      r_rxValid  <= 1'b0;
      r_rxId     <= '0;
      r_rxData   <= '0;
      r_frameErr <= 1'b0;
    end else begin
      r_rdyDly   <= uart_rx_ready;
      r_rxValid  <= 1'b0;
      r_frameErr <= 1'b0;
      r_rxTimer  <= (w_strobe || r_rxState == HUNT) ? '0 : r_rxTimer + 1'b1;
      if (r_rxState == HUNT) begin
        if (w_strobe) begin
          if (w_hdrOk) begin
            r_hdrId <= uart_rx_data[ID_W-1:0];
            r_rxCnt <= '0;
          end else begin
            r_frameErr <= 1'b1;
          end
        end
      end else if (w_strobe) begin
        r_rxShift <= w_shiftNext;
        r_rxCnt   <= r_rxCnt + 1'b1;
        if (w_last) begin
          r_rxData  <= w_shiftNext;
          r_rxId    <= r_hdrId;
          r_rxValid <= 1'b1;
        end
      end else if (w_timeout) begin
        r_frameErr <= 1'b1;
        r_rxShift  <= '0;
      end
    end
  end

  assign rx_valid  = r_rxValid;
  assign rx_id     = r_rxId;
  assign rx_data   = r_rxData;
  assign frame_err = r_frameErr;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Self-checking bench for uart_link_ctrl.
// Contains a busy-pulse UART model, a negedge monitor and scoreboard queues.
module tb_uart_link_ctrl;

  localparam int NUM_REQ    = 2;
  localparam int DATA_WIDTH = 32;
  localparam int RX_TIMEOUT = 200;

  logic                          clk = 1'b0;
  logic                          rstn = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic [7:0]                    uart_data;
  logic                          uart_en;
  logic                          uart_tx_busy;
  logic                          uart_rx_ready = 1'b0;
  logic [7:0]                    uart_rx_data = 8'h00;
  logic                          rx_valid;
  logic [1:0]                    rx_id;
  logic [DATA_WIDTH-1:0]         rx_data;
  logic                          frame_err;

  int checks = 0;
  int errors = 0;
  int errSeen = 0;
  int bcnt;
  logic [7:0]         txExp[$];
  logic [7:0]         txObs[$];
  logic [NUM_REQ-1:0] grantObs[$];
  logic [33:0]        rxExp[$];
  logic [33:0]        rxObs[$];

  uart_link_ctrl #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .RX_TIMEOUT(RX_TIMEOUT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_data     (uart_data),
    .uart_en       (uart_en),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_ready (uart_rx_ready),
    .uart_rx_data  (uart_rx_data),
    .rx_valid      (rx_valid),
    .rx_id         (rx_id),
    .rx_data       (rx_data),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy rises the cycle after data_en and stays up for 10 cycles.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      uart_tx_busy <= 1'b0;
      bcnt         <= 0;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) uart_tx_busy <= 1'b0;
    end else if (uart_en) begin
      uart_tx_busy <= 1'b1;
      bcnt         <= 10;
    end
  end

  // Monitor: records DUT output events mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (uart_en) txObs.push_back(uart_data);
      if (req_ready != '0) grantObs.push_back(req_ready);
      if (rx_valid) rxObs.push_back({rx_id, rx_data});
      if (frame_err) errSeen++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_all();
    txExp.delete(); txObs.delete(); grantObs.delete();
    rxExp.delete(); rxObs.delete(); errSeen = 0;
  endtask

  task automatic push_frame(input logic [1:0] id, input logic [31:0] w);
    txExp.push_back({4'hA, 2'b00, id});
    for (int b = 0; b < 4; b++) txExp.push_back(w[8*b +: 8]);
  endtask

  task automatic send_rx_byte(input logic [7:0] b, input int gap);
    uart_rx_data  = b;
    uart_rx_ready = 1'b1;
    tick(2);
    uart_rx_ready = 1'b0;
    tick(gap);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 2'b01;
    req_data[31:0] = 32'h11223344;
    tick(3);
    checks++; if (uart_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_uart_en: got %b expected 0", uart_en); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_uart_data: got %h expected 00", uart_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_id !== 2'b00) begin errors++; $display("[TB] FAIL reset_rx_id: got %h expected 0", rx_id); end
    checks++; if (rx_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 0", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    req_valid = '0;
    rstn = 1'b1;
    tick(2);
  endtask

  task automatic test_single_req();
    int t;
    logic [7:0] e, a;
    clear_all();
    push_frame(2'd0, 32'h11223344);
    req_data[31:0] = 32'h11223344;
    req_valid = 2'b01;
    t = 0;
    while (grantObs.size() == 0 && t < 50) begin tick(1); t++; end
    req_valid = '0;
    checks++; if (grantObs.size() == 0) begin errors++; $display("[TB] FAIL single_grant: got no req_ready within 50 cycles, expected one"); end
    t = 0;
    while (txObs.size() < 5 && t < 300) begin tick(1); t++; end
    tick(30);
    checks++; if (txObs.size() != 5) begin errors++; $display("[TB] FAIL single_byte_count: got %0d expected 5", txObs.size()); end
    for (int k = 0; k < 5; k++) begin
      e = txExp.pop_front();
      a = (txObs.size() > 0) ? txObs.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("[TB] FAIL single_byte%0d: got %h expected %h", k, a, e); end
    end
    checks++; if (grantObs.size() != 1 || grantObs[0] !== 2'b01) begin
      errors++; $display("[TB] FAIL single_ready: got %0d pulses (first %b) expected 1 pulse 01", grantObs.size(), grantObs[0]);
    end
  endtask

  task automatic test_round_robin();
    int t;
    logic [7:0] e, a;
    logic [NUM_REQ-1:0] g, ge;
    rstn = 1'b0;
    tick(2);
    clear_all();
    rstn = 1'b1;
    tick(1);
    req_data = {32'hB1B2B3B4, 32'hA1A2A3A4};
    push_frame(2'd0, 32'hA1A2A3A4);
    push_frame(2'd1, 32'hB1B2B3B4);
    push_frame(2'd0, 32'hA1A2A3A4);
    push_frame(2'd1, 32'hB1B2B3B4);
    req_valid = 2'b11;
    t = 0;
    while (grantObs.size() < 4 && t < 1000) begin tick(1); t++; end
    req_valid = '0;
    checks++; if (grantObs.size() != 4) begin errors++; $display("[TB] FAIL rr_grant_count: got %0d expected 4", grantObs.size()); end
    t = 0;
    while (txObs.size() < 20 && t < 400) begin tick(1); t++; end
    tick(30);
    checks++; if (txObs.size() != 20) begin errors++; $display("[TB] FAIL rr_byte_count: got %0d expected 20", txObs.size()); end
    for (int k = 0; k < 20; k++) begin
      e = txExp.pop_front();
      a = (txObs.size() > 0) ? txObs.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("[TB] FAIL rr_byte%0d: got %h expected %h", k, a, e); end
    end
    for (int k = 0; k < 4; k++) begin
      ge = (k % 2 == 0) ? 2'b01 : 2'b10;
      g = (grantObs.size() > 0) ? grantObs.pop_front() : 2'bxx;
      checks++; if (g !== ge) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, g, ge); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    logic [7:0] e, a;
    clear_all();
    req_data[31:0] = 32'h11223344;
    req_valid = 2'b01;
    t = 0;
    while (txObs.size() < 3 && t < 200) begin tick(1); t++; end
    checks++; if (txObs.size() < 3) begin errors++; $display("[TB] FAIL midrst_progress: got %0d bytes expected 3", txObs.size()); end
    tick(4);
    rstn = 1'b0;
    #1;
    checks++; if (uart_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_uart_en: got %b expected 0", uart_en); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL midrst_req_ready: got %b expected 00", req_ready); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_idle: uart_data got %h expected 00", uart_data); end
    tick(2);
    clear_all();
    push_frame(2'd0, 32'h11223344);
    rstn = 1'b1;
    t = 0;
    while (grantObs.size() == 0 && t < 50) begin tick(1); t++; end
    req_valid = '0;
    t = 0;
    while (txObs.size() < 5 && t < 300) begin tick(1); t++; end
    tick(30);
    checks++; if (txObs.size() != 5) begin errors++; $display("[TB] FAIL midrst_byte_count: got %0d expected 5", txObs.size()); end
    for (int k = 0; k < 5; k++) begin
      e = txExp.pop_front();
      a = (txObs.size() > 0) ? txObs.pop_front() : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("[TB] FAIL midrst_byte%0d: got %h expected %h", k, a, e); end
    end
    checks++; if (grantObs.size() != 1) begin errors++; $display("[TB] FAIL midrst_ready: got %0d pulses expected 1", grantObs.size()); end
  endtask

  task automatic test_rx_frame();
    logic [33:0] e, a;
    clear_all();
    rxExp.push_back({2'd1, 32'hDEADBEEF});
    send_rx_byte(8'hA1, 50);
    send_rx_byte(8'hEF, 50);
    send_rx_byte(8'hBE, 50);
    send_rx_byte(8'hAD, 50);
    send_rx_byte(8'hDE, 5);
    checks++; if (rxObs.size() != 1) begin errors++; $display("[TB] FAIL rx_valid_count: got %0d expected 1", rxObs.size()); end
    e = rxExp.pop_front();
    a = (rxObs.size() > 0) ? rxObs.pop_front() : 34'hx;
    checks++; if (a !== e) begin errors++; $display("[TB] FAIL rx_word: got %h expected %h", a, e); end
    checks++; if (errSeen != 0) begin errors++; $display("[TB] FAIL rx_no_err: got %0d frame_err pulses expected 0", errSeen); end
    tick(20);
    checks++; if ({rx_id, rx_data} !== e) begin errors++; $display("[TB] FAIL rx_hold: got %h expected %h", {rx_id, rx_data}, e); end
  endtask

  task automatic test_rx_bad_header();
    logic [33:0] e, a;
    clear_all();
    send_rx_byte(8'h55, 10);
    rxExp.push_back({2'd0, 32'h00000001});
    send_rx_byte(8'hA0, 20);
    send_rx_byte(8'h01, 20);
    send_rx_byte(8'h00, 20);
    send_rx_byte(8'h00, 20);
    send_rx_byte(8'h00, 5);
    checks++; if (errSeen != 1) begin errors++; $display("[TB] FAIL badhdr_err: got %0d frame_err pulses expected 1", errSeen); end
    checks++; if (rxObs.size() != 1) begin errors++; $display("[TB] FAIL badhdr_valid_count: got %0d expected 1", rxObs.size()); end
    e = rxExp.pop_front();
    a = (rxObs.size() > 0) ? rxObs.pop_front() : 34'hx;
    checks++; if (a !== e) begin errors++; $display("[TB] FAIL badhdr_word: got %h expected %h", a, e); end
  endtask

  task automatic test_rx_timeout();
    int t;
    logic [33:0] e, a;
    clear_all();
    send_rx_byte(8'hA2, 10);
    send_rx_byte(8'h01, 0);
    tick(185);
    checks++; if (errSeen != 0) begin errors++; $display("[TB] FAIL timeout_early: got %0d frame_err pulses before %0d cycles expected 0", errSeen, RX_TIMEOUT); end
    t = 0;
    while (errSeen == 0 && t < 40) begin tick(1); t++; end
    checks++; if (errSeen != 1) begin errors++; $display("[TB] FAIL timeout_err: got %0d frame_err pulses expected 1", errSeen); end
    checks++; if (rxObs.size() != 0) begin errors++; $display("[TB] FAIL timeout_no_valid: got %0d rx_valid pulses expected 0", rxObs.size()); end
    rxExp.push_back({2'd2, 32'hCAFEF00D});
    send_rx_byte(8'hA2, 20);
    send_rx_byte(8'h0D, 20);
    send_rx_byte(8'hF0, 20);
    send_rx_byte(8'hFE, 20);
    send_rx_byte(8'hCA, 5);
    e = rxExp.pop_front();
    a = (rxObs.size() > 0) ? rxObs.pop_front() : 34'hx;
    checks++; if (a !== e) begin errors++; $display("[TB] FAIL timeout_recover: got %h expected %h", a, e); end
    checks++; if (errSeen != 1) begin errors++; $display("[TB] FAIL timeout_recover_err: got %0d frame_err pulses expected 1", errSeen); end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_reset_mid_frame();
    test_rx_frame();
    test_rx_bad_header();
    test_rx_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
- Controller that shares one `uart` instance (8-bit TX/RX) between up to 4 on-chip requesters.
- TX side: round-robin arbitration between requesters. Each granted 32-bit word is framed as 1 header byte (0xA0 | requester id) followed by 4 data bytes, LSB first.
- TX sequencing: drives the UART's data_input/data_en and sequences on tx_busy.
- RX side: reassembles incoming 5-byte frames into (id, word) and emits a one-cycle valid pulse. Used as the debug/host link beside the system bus.

Parameters:
- NUM_REQ, 2, number of TX requesters (1..4).
- DATA_WIDTH, 32, payload width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
- RX_TIMEOUT, 100000, clk cycles allowed between RX bytes of one frame before it is abandoned.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened words; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- uart_data  out  8  to uart data_input.
- uart_en  out  1  to uart data_en; one-cycle pulse per byte.
- uart_tx_busy  in  1  from uart tx_busy.
- uart_rx_ready  in  1  from uart ready.
- uart_rx_data  in  8  from uart data_output.
- rx_valid  out  1  one-cycle pulse; frame received.
- rx_id  out  2  requester id from the header.
- rx_data  out  DATA_WIDTH  assembled word.
- frame_err  out  1  one-cycle pulse; RX timeout or non-header byte discarded.

Behaviour:
- Reset values: all outputs 0; rr_ptr = 0; TX FSM IDLE; RX FSM HUNT.
- Async assert of rstn aborts any frame in flight. No partial frame resumes after reset.
- Every output and state register is synchronous to clk.
- TX arbitration:
  - In IDLE, choose the first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  - Grant cycle: pulse req_ready for that requester, latch its data and id, and set rr_ptr = winner+1 (mod NUM_REQ).
  - A requester must hold req_valid and req_data stable until req_ready.
  - Words never interleave; a frame completes before the next grant.
- TX FSM, states IDLE -> LOAD -> WAIT_BUSY -> WAIT_DONE -> (LOAD | IDLE):
  - LOAD: uart_data = current byte, uart_en = 1 for exactly one cycle. Byte index 0 is the header; indices 1..BYTES are data[8*(k-1) +: 8].
  - WAIT_BUSY: wait for uart_tx_busy = 1.
  - WAIT_DONE: wait for uart_tx_busy = 0. Then either index++ and go to LOAD, or go to IDLE after the last byte.
  - LOAD is never entered while uart_tx_busy = 1. If busy is already high on entry to LOAD, stay in LOAD with uart_en held 0.
  - uart_data is held stable from LOAD until WAIT_DONE exits.
- Minimum grant-to-grant spacing: one full frame plus 1 IDLE cycle.
- RX byte strobe: a byte is taken on the rising edge of uart_rx_ready, detected with a 1-flop delay. Level-high ready never double-counts.
- RX FSM:
  - HUNT: a byte with upper nibble 0xA becomes the header; latch id = byte[1:0]; go to DATA with count = 0. Any other byte pulses frame_err and stays in HUNT.
  - DATA: each byte fills rx_shift[8*count +: 8] and increments count.
  - On byte BYTES: rx_data/rx_id update and rx_valid pulses in the same cycle; return to HUNT.
  - rx_data/rx_id hold their value until the next frame completes.
- RX timeout: a counter clears on each strobe and counts while in DATA. Reaching RX_TIMEOUT pulses frame_err, drops the partial word, and returns to HUNT.
- TX and RX are fully independent; simultaneous activity is legal.

Decomposition:
- Shared package uart_link_pkg holds:
  - HDR_MAGIC = 4'hA.
  - TX state enum {IDLE, LOAD, WAIT_BUSY, WAIT_DONE}.
  - RX state enum {HUNT, DATA}.
  - ID_W = 2.
- One natural sub-module, rr_arbiter: NUM_REQ-wide round-robin, combinational pick plus registered pointer. The top holds both FSMs.

Test Plan:
- Req0 only, data 0x11223344; UART model asserts busy 1 cycle after en and holds it 10 cycles -> uart_en pulses 5 times with bytes A0,44,33,22,11; req_ready[0] pulses once.
- Req0 and req1 valid together and continuously -> frame order id0,id1,id0,id1; headers A0,A1 alternate; no interleaved bytes.
- RX bytes A1,EF,BE,AD,DE, each a 2-cycle ready pulse, 50 cycles apart -> rx_valid pulses once; rx_id = 1; rx_data = 0xDEADBEEF; no frame_err.
- RX 0x55, then a valid A0 frame carrying 0x00000001 -> frame_err pulses once for 0x55; rx_valid with rx_id = 0, rx_data = 1.
- RX A2,01, then silence for RX_TIMEOUT cycles (set to 200) -> frame_err at timeout, no rx_valid. A following A2 frame then decodes correctly.
- Assert rstn = 0 during WAIT_DONE of byte 2 -> uart_en and req_ready immediately 0, FSM IDLE. After release with req0 still valid, the frame restarts from header A0.
